// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : load_store_unit
//  Purpose  : Single-outstanding load/store sequencer (IDLE/REQ/RESP) with
//             lane steering, load extension and a bus timeout.
//  Revision : 1.0  initial release
// ============================================================================
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] rs1_value,
    input  logic [31:0] rs2_value,
    input  logic [31:0] immediate,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic [31:0] load_data,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam int              CW     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]   C_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_is_store;
    logic [2:0]  r_funct3;
    logic [1:0]  r_off;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic [31:0] r_load_data;
    logic        r_fault;
    logic [CW-1:0] r_cnt;

    logic [31:0] w_ea;
    logic        w_illegal;
    logic        w_misaligned;
    logic        w_pre_fault;
    logic [31:0] w_wdata;
    logic [3:0]  w_wstrb;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_ext;
    logic        w_expire;

    assign w_ea = rs1_value + immediate;

    // Only B/H/W (and BU/HU for loads) are legal encodings.
    always_comb begin
        w_illegal    = is_store ? (funct3[2] || (funct3[1:0] == 2'b11))
                                : ((funct3 == 3'b011) || (funct3[2:1] == 2'b11));
        w_misaligned = ((funct3[1:0] == 2'b01) && w_ea[0]) ||
                       ((funct3[1:0] == 2'b10) && (w_ea[1:0] != 2'b00));
        w_pre_fault  = w_illegal || w_misaligned;
    end

    always_comb begin
        w_wdata = rs2_value;
        w_wstrb = 4'b1111;
        case (funct3[1:0])
            2'b00: begin
                w_wdata = {4{rs2_value[7:0]}};
                w_wstrb = 4'b0001 << w_ea[1:0];
            end
            2'b01: begin
                w_wdata = {2{rs2_value[15:0]}};
                w_wstrb = 4'b0011 << w_ea[1:0];
            end
            default: begin
                w_wdata = rs2_value;
                w_wstrb = 4'b1111;
            end
        endcase
    end

    always_comb begin
        w_byte     = mem_rdata[{r_off, 3'b000} +: 8];
        w_half     = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        w_load_ext = mem_rdata;
        case (r_funct3)
            3'b000:  w_load_ext = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load_ext = {24'd0, w_byte};
            3'b001:  w_load_ext = {{16{w_half[15]}}, w_half};
            3'b101:  w_load_ext = {16'd0, w_half};
            default: w_load_ext = mem_rdata;
        endcase
    end

    assign w_expire = (r_cnt == C_LAST);

    // An ack on the expiry cycle takes precedence over the timeout.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = w_pre_fault ? S_RESP : S_REQ;
            S_REQ:   if (mem_ack || w_expire) w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_is_store  <= 1'b0;
            r_funct3    <= 3'd0;
            r_off       <= 2'd0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_wstrb     <= 4'd0;
            r_load_data <= 32'd0;
            r_fault     <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_is_store <= is_store;
                        r_funct3   <= funct3;
                        r_off      <= w_ea[1:0];
                        r_addr     <= {w_ea[31:2], 2'b00};
                        r_wdata    <= w_wdata;
                        r_wstrb    <= w_wstrb;
                        r_fault    <= w_pre_fault;
                        r_cnt      <= '0;
                    end
                end
                S_REQ: begin
                    if (mem_ack) begin
                        r_fault <= 1'b0;
                        if (!r_is_store) r_load_data <= w_load_ext;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        if (w_expire) r_fault <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_RESP);
    assign fault     = done && r_fault;
    assign mem_rd    = (r_state == S_REQ) && !r_is_store;
    assign mem_wr    = (r_state == S_REQ) && r_is_store;
    assign mem_wstrb = mem_wr ? r_wstrb : 4'b0000;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign load_data = r_load_data;

endmodule
`default_nettype wire
